double_buffered_framebuffer: RTL and testbench

//  Two-bank pixel store between the GPU draw pipeline and the display scan-out. Draw side

---
 rtl/gpu_fb_pkg.sv | 14 +
 rtl/double_buffered_framebuffer_ram.sv | 49 ++++
 rtl/double_buffered_framebuffer.sv | 152 +++++++++++++++
 tb/tb_double_buffered_framebuffer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_fb_pkg.sv
// Shared definitions for the double-buffered framebuffer:
// FSM state encoding and default bank geometry.
package gpu_fb_pkg;

   localparam int DEF_WIDTH = 9;
   localparam int DEF_DEPTH = 2048;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_SWAP_WAIT
   } fb_state_e;

endpackage

// File: rtl/double_buffered_framebuffer_ram.sv
// One pixel bank: a write/read port (A) and a read-only port (B),
// both with 1-cycle registered reads.
// Ports: clk, reset (async, high), A: we/re/addr/wdata -> rdata
// (holds when not reading), B: addr -> rdata (every cycle).
module fb_bank_ram
   import gpu_fb_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_we_i,
   input  logic              a_re_i,
   input  logic [ADDR_W-1:0] a_addr_i,
   input  logic [WIDTH-1:0]  a_wdata_i,
   output logic [WIDTH-1:0]  a_rdata_o,
   input  logic [ADDR_W-1:0] b_addr_i,
   output logic [WIDTH-1:0]  b_rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] a_rdata_q;
   logic [WIDTH-1:0] b_rdata_q;

   // Storage has no reset: contents survive a reset untouched.
   always_ff @(posedge clk) begin
      if (a_we_i) begin
         mem_q[a_addr_i] <= a_wdata_i;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         if (a_re_i) begin
            a_rdata_q <= mem_q[a_addr_i];
         end
         b_rdata_q <= mem_q[b_addr_i];
      end
   end

   assign a_rdata_o = a_rdata_q;
   assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/double_buffered_framebuffer.sv
// Two-bank framebuffer: draw side owns the back bank, display reads
// the front bank; banks swap on a vblank rising edge after a request.
// Ports: draw_* (back-bank R/W, gated by draw_ready), clear_* (fill
// engine), swap_request/vblank/swap_pending/front_bank, disp_* (scan).
module double_buffered_framebuffer
   import gpu_fb_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] draw_addr,
   input  logic [WIDTH-1:0]  draw_data_in,
   input  logic              draw_write_en,
   input  logic              draw_read_en,
   output logic [WIDTH-1:0]  draw_data_out,
   output logic              draw_ready,
   input  logic              clear_start,
   input  logic [WIDTH-1:0]  clear_colour,
   output logic              clear_busy,
   input  logic              swap_request,
   input  logic              vblank,
   output logic              swap_pending,
   output logic              front_bank,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [WIDTH-1:0]  disp_data_out
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   fb_state_e         state_q;
   logic              front_q;
   logic              pending_q;
   logic [ADDR_W-1:0] clear_addr_q;
   logic [WIDTH-1:0]  colour_q;
   logic              vblank_q;
   logic              armed_q;
   logic              draw_sel_q;
   logic              disp_sel_q;

   logic              vblank_rise;
   logic              back;
   logic              clr_wr;
   logic              draw_wr;
   logic              draw_rd;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [WIDTH-1:0]  a_wdata;
   logic [WIDTH-1:0]  a_rdata [2];
   logic [WIDTH-1:0]  b_rdata [2];

   // armed_q blocks a vblank that is already high out of reset from
   // looking like a rising edge until it has been seen low.
   assign vblank_rise = vblank & ~vblank_q & armed_q;

   assign draw_ready = (state_q == ST_IDLE) & ~pending_q;
   assign clear_busy = (state_q == ST_CLEAR);
   assign swap_pending = pending_q;
   assign front_bank = front_q;
   assign back = ~front_q;

   assign clr_wr = clear_busy;
   assign draw_wr = draw_ready & draw_write_en;
   assign draw_rd = draw_ready & draw_read_en & ~draw_write_en;

   assign a_we = clr_wr | draw_wr;
   assign a_addr = clr_wr ? clear_addr_q : draw_addr;
   assign a_wdata = clr_wr ? colour_q : draw_data_in;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fb_bank_ram #(
         .WIDTH(WIDTH),
         .DEPTH(DEPTH)
      ) u_ram (
         .clk      (clk),
         .reset    (reset),
         .a_we_i   (a_we & (back == b[0])),
         .a_re_i   (draw_rd & (back == b[0])),
         .a_addr_i (a_addr),
         .a_wdata_i(a_wdata),
         .a_rdata_o(a_rdata[b]),
         .b_addr_i (disp_addr),
         .b_rdata_o(b_rdata[b])
      );
   end

   // Output selects remember which bank produced the held data, so a
   // swap does not change draw_data_out until the next accepted read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         draw_sel_q <= 1'b0;
         disp_sel_q <= 1'b0;
      end else begin
         if (draw_rd) begin
            draw_sel_q <= back;
         end
         disp_sel_q <= front_q;
      end
   end

   assign draw_data_out = draw_sel_q ? a_rdata[1] : a_rdata[0];
   assign disp_data_out = disp_sel_q ? b_rdata[1] : b_rdata[0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         front_q      <= 1'b0;
         pending_q    <= 1'b0;
         clear_addr_q <= '0;
         colour_q     <= '0;
         vblank_q     <= 1'b0;
         armed_q      <= 1'b0;
      end else begin
         vblank_q <= vblank;
         if (!vblank) begin
            armed_q <= 1'b1;
         end
         pending_q <= pending_q | swap_request;
         unique case (state_q)
            ST_IDLE: begin
               if (clear_start) begin
                  state_q      <= ST_CLEAR;
                  colour_q     <= clear_colour;
                  clear_addr_q <= '0;
               end else if (swap_request | pending_q) begin
                  state_q <= ST_SWAP_WAIT;
               end
            end
            ST_CLEAR: begin
               clear_addr_q <= clear_addr_q + ADDR_W'(1);
               if (clear_addr_q == LAST_ADDR) begin
                  clear_addr_q <= '0;
                  state_q <= (pending_q | swap_request) ?
                             ST_SWAP_WAIT : ST_IDLE;
               end
            end
            ST_SWAP_WAIT: begin
               // A request landing on the swap edge merges into it.
               if (vblank_rise) begin
                  front_q   <= ~front_q;
                  pending_q <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_double_buffered_framebuffer.sv
// Randomised bench for double_buffered_framebuffer against a
// behavioural two-bank model, plus directed literal checks.
module tb_double_buffered_framebuffer;

   localparam int W  = 9;
   localparam int D  = 2048;
   localparam int AW = 11;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] draw_addr = '0;
   logic [W-1:0]  draw_data_in = '0;
   logic          draw_write_en = 1'b0;
   logic          draw_read_en = 1'b0;
   logic [W-1:0]  draw_data_out;
   logic          draw_ready;
   logic          clear_start = 1'b0;
   logic [W-1:0]  clear_colour = '0;
   logic          clear_busy;
   logic          swap_request = 1'b0;
   logic          vblank = 1'b0;
   logic          swap_pending;
   logic          front_bank;
   logic [AW-1:0] disp_addr = '0;
   logic [W-1:0]  disp_data_out;

   double_buffered_framebuffer dut (
      .clk          (clk),
      .reset        (reset),
      .draw_addr    (draw_addr),
      .draw_data_in (draw_data_in),
      .draw_write_en(draw_write_en),
      .draw_read_en (draw_read_en),
      .draw_data_out(draw_data_out),
      .draw_ready   (draw_ready),
      .clear_start  (clear_start),
      .clear_colour (clear_colour),
      .clear_busy   (clear_busy),
      .swap_request (swap_request),
      .vblank       (vblank),
      .swap_pending (swap_pending),
      .front_bank   (front_bank),
      .disp_addr    (disp_addr),
      .disp_data_out(disp_data_out)
   );

   always #5 clk = ~clk;

   int total = 0;
   int passed = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   // Model: memory of -1 means "never written" (value unknown).
   int m_mem [2][D];
   bit m_front, m_pend, m_clr, m_vprev, m_armed, m_swapped;
   bit m_edge, m_rdy, m_bk;
   int m_cnt, m_colour, m_dout, m_disp;

   initial begin
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < D; a++) m_mem[b][a] = -1;
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_front = 0; m_pend = 0; m_clr = 0; m_cnt = 0;
         m_vprev = 0; m_armed = 0; m_dout = 0; m_disp = 0;
      end else begin
         m_edge = vblank && !m_vprev && m_armed;
         m_rdy = !m_clr && !m_pend;
         m_bk = !m_front;
         m_swapped = 0;
         m_disp = m_mem[m_front][disp_addr];
         if (m_rdy && draw_write_en)
            m_mem[m_bk][draw_addr] = int'(draw_data_in);
         else if (m_rdy && draw_read_en)
            m_dout = m_mem[m_bk][draw_addr];
         if (m_clr) begin
            m_mem[m_bk][m_cnt] = m_colour;
            m_cnt++;
            if (m_cnt == D) m_clr = 0;
         end else if (m_pend) begin
            if (m_edge) begin
               m_front = !m_front;
               m_pend = 0;
               m_swapped = 1;
            end
         end else if (clear_start) begin
            m_clr = 1; m_cnt = 0; m_colour = int'(clear_colour);
         end
         if (swap_request && !m_swapped) m_pend = 1;
         m_vprev = vblank;
         if (!vblank) m_armed = 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en && !reset) begin
         chk("front_bank", int'(front_bank), int'(m_front));
         chk("draw_ready", int'(draw_ready), int'(!m_clr && !m_pend));
         chk("clear_busy", int'(clear_busy), int'(m_clr));
         chk("swap_pending", int'(swap_pending), int'(m_pend));
         if (m_dout >= 0) chk("draw_data_out", int'(draw_data_out), m_dout);
         if (m_disp >= 0) chk("disp_data_out", int'(disp_data_out), m_disp);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         clear_start = 0; swap_request = 0;
         draw_write_en = 0; draw_read_en = 0;
      end
   endtask

   task automatic wr(input int a, input int v);
      draw_addr = AW'(a); draw_data_in = W'(v); draw_write_en = 1;
      step(1);
   endtask

   task automatic rd_chk(input string nm, input int a, input int exp);
      draw_addr = AW'(a); draw_read_en = 1;
      step(1);
      chk(nm, int'(draw_data_out), exp);
   endtask

   task automatic wait_clear_done(input string nm);
      int n = 0;
      while (clear_busy && n < 3000) begin n++; step(1); end
      if (n >= 3000) chk({nm, "_timeout"}, n, 0);
   endtask

   int n;
   int bad;

   initial begin
      step(3);
      reset = 0;
      chk_en = 1;
      // Reset state.
      chk("rst_front", int'(front_bank), 0);
      chk("rst_ready", int'(draw_ready), 1);
      chk("rst_busy", int'(clear_busy), 0);
      chk("rst_pending", int'(swap_pending), 0);
      chk("rst_dout", int'(draw_data_out), 0);
      chk("rst_disp", int'(disp_data_out), 0);

      // Back-bank write/read; front bank not touched.
      wr(5, 'h1AB);
      rd_chk("rd5", 5, 'h1AB);
      disp_addr = 5;
      step(1);
      chk("disp5_not_back", int'(disp_data_out != 'h1AB), 1);

      // Swap at vblank rising edge.
      swap_request = 1;
      step(1);
      chk("swap_pend", int'(swap_pending), 1);
      chk("swap_ready_low", int'(draw_ready), 0);
      step(3);
      chk("no_swap_yet", int'(front_bank), 0);
      vblank = 1;
      step(1);
      chk("swapped_front", int'(front_bank), 1);
      chk("swapped_pend", int'(swap_pending), 0);
      step(1);
      chk("disp5_after_swap", int'(disp_data_out), 'h1AB);
      vblank = 0;

      // Clear of back bank (bank 0).
      clear_colour = 'h0F3; clear_start = 1;
      step(1);
      n = 0; bad = 0;
      while (clear_busy && n < 3000) begin
         if (draw_ready) bad++;
         n++;
         step(1);
      end
      chk("clear_cycles", n, D);
      chk("clear_ready_low", bad, 0);
      rd_chk("clr_rd0", 0, 'h0F3);
      rd_chk("clr_rd5", 5, 'h0F3);
      rd_chk("clr_rd_last", D - 1, 'h0F3);
      chk("clr_disp_keep", int'(disp_data_out), 'h1AB);

      // Clear + swap together; edges during clear must not swap.
      clear_colour = 'h055; clear_start = 1; swap_request = 1;
      step(1);
      chk("cs_busy", int'(clear_busy), 1);
      chk("cs_pend", int'(swap_pending), 1);
      step(500);
      vblank = 1; step(2); vblank = 0; step(2);
      chk("cs_no_swap", int'(front_bank), 1);
      wait_clear_done("cs");
      chk("cs_after_front", int'(front_bank), 1);
      chk("cs_after_pend", int'(swap_pending), 1);
      step(3);
      vblank = 1;
      step(1);
      chk("cs_swap_front", int'(front_bank), 0);
      chk("cs_swap_pend", int'(swap_pending), 0);
      vblank = 0;
      step(1);

      // Reset in the middle of a clear (back bank is 1).
      wr(100, 'h111); wr(101, 'h122); wr(500, 'h133);
      clear_colour = 'h1C7; clear_start = 1;
      step(1);
      n = 0;
      while (m_cnt != 100 && n < 300) begin n++; step(1); end
      chk("mid_reach100", int'(n < 300), 1);
      #1 reset = 1;
      #1 chk("mid_busy_drop", int'(clear_busy), 0);
      step(2);
      reset = 0;
      step(1);
      rd_chk("mid_rd0", 0, 'h1C7);
      rd_chk("mid_rd99", 99, 'h1C7);
      rd_chk("mid_rd100", 100, 'h111);
      rd_chk("mid_rd101", 101, 'h122);
      rd_chk("mid_rd500", 500, 'h133);

      // Randomised traffic against the model.
      for (int i = 0; i < 8000; i++) begin
         if ($urandom_range(19) == 0) vblank = ~vblank;
         swap_request = ($urandom_range(59) == 0);
         clear_start = ($urandom_range(1499) == 0);
         clear_colour = W'($urandom);
         draw_write_en = ($urandom_range(2) == 0);
         draw_read_en = ($urandom_range(1) == 0);
         draw_data_in = W'($urandom);
         draw_addr = ($urandom_range(7) == 0) ?
                     AW'($urandom) : AW'($urandom_range(31));
         disp_addr = AW'($urandom_range(31));
         step(1);
      end
      wait_clear_done("end");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
